// File: rtl/tc_pkg.sv
// Shared definitions for the timer_counter peripheral: register offsets,
// CTRL field positions, MODE values and FSM state encoding.
package tc_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_AUTO    = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Registers CTRL/PRESET/COUNT; irq is the registered AND of PEND and IM.
module timer_counter
  import tc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_e      state_q;
  logic        en_q;
  logic [1:0]  mode_q;
  logic        im_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        pend_q;
  logic        irq_q;

  logic [1:0]  offset;
  logic        wr_en;
  logic        ctrl_we;
  logic        preset_we;
  logic        auto_reload;
  logic        unused_addr;

  assign offset      = addr[3:2];
  assign wr_en       = (byteen == 4'b1111);
  assign ctrl_we     = wr_en && (offset == OFF_CTRL);
  assign preset_we   = wr_en && (offset == OFF_PRESET);
  assign auto_reload = (mode_q == MODE_AUTO);
  assign unused_addr = ^{addr[31:4], addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= pend_q & im_q;

      if (preset_we) preset_q <= wdata;

      if (ctrl_we) begin
        mode_q <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
        im_q   <= wdata[CTRL_IM];
      end

      // A CPU CTRL write takes priority over the FSM's own EN/PEND updates.
      if (ctrl_we)                             en_q <= wdata[CTRL_EN];
      else if (state_q == ST_INT && !auto_reload) en_q <= 1'b0;

      if (ctrl_we)                      pend_q <= 1'b0;
      else if (state_q == ST_INT)       pend_q <= 1'b1;
      else if (pend_q && auto_reload)   pend_q <= 1'b0;

      case (state_q)
        ST_IDLE: if (en_q) state_q <= ST_LOAD;
        ST_LOAD: begin
          count_q <= preset_q;
          state_q <= ST_CNT;
        end
        ST_CNT: begin
          if (!en_q)                state_q <= ST_IDLE;
          else if (count_q == '0)   state_q <= ST_INT;
          else                      count_q <= count_q - 32'd1;
        end
        ST_INT:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_CTRL:   rdata = {28'd0, im_q, mode_q, en_q};
      OFF_PRESET: rdata = preset_q;
      OFF_COUNT:  rdata = count_q;
      default:    rdata = '0;
    endcase
  end

  assign irq = irq_q;

endmodule
